mem_request_responder: RTL and testbench

//  Memory-side responder for the pipeline's request/hit protocol. Accepts imemREN and dmemREN/dmemWEN.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/mem_grant_arb.sv | 36 +++
 rtl/mem_request_responder.sv | 150 +++++++++++++++
 tb/tb_mem_request_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-interface types: word type, RAM handshake state and responder FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    IACC,
    DACC,
    IRESP,
    DRESP
  } resp_state_t;

  // Poison value returned when an access is aborted by the timeout.
  localparam word_t BAD_LOAD = 32'hBAD0BAD0;

endpackage

// File: rtl/mem_grant_arb.sv
// Grant arbiter for mem_request_responder: data-over-instruction priority with a starvation
// counter that forces a waiting instruction fetch through after STARVE_MAX data grants.
module mem_grant_arb
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic ireq,
  input  logic dreq,
  output logic grant_i,
  output logic grant_d
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_cnt;
  logic            starved;

  assign starved = (starve_cnt == CntW'(STARVE_MAX));
  assign grant_d = idle & dreq & ~(ireq & starved);
  assign grant_i = idle & ireq & ~grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && ireq && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_request_responder.sv
// Memory-side responder: arbitrates instruction/data requests onto one RAM port and returns
// registered hit pulses. Define MEM_RESP_TIMEOUT_EN to add the access timeout and memerr port.
module mem_request_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      imemREN,
  input  word_t     imemaddr,
  input  logic      dmemREN,
  input  logic      dmemWEN,
  input  word_t     dmemaddr,
  input  word_t     dmemstore,
  output logic      ihit,
  output logic      dhit,
  output word_t     imemload,
  output word_t     dmemload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
`ifdef MEM_RESP_TIMEOUT_EN
  ,
  output logic      memerr
`endif
);

  resp_state_t state;
  logic        wr_op;
  logic        dropped;
  logic        idle;
  logic        dreq;
  logic        grant_i;
  logic        grant_d;
  logic        req_live;
  logic        done;
  logic        abort;
  word_t       load_val;

  assign idle     = (state == IDLE);
  assign dreq     = dmemREN | dmemWEN;
  assign req_live = (state == IACC) ? imemREN : dreq;
  assign done     = (ramstate == ACCESS);
  assign load_val = abort ? BAD_LOAD : ramload;

  mem_grant_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk    (CLK),
    .rst_n  (nRST),
    .idle   (idle),
    .ireq   (imemREN),
    .dreq   (dreq),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

`ifdef MEM_RESP_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  logic [WaitW-1:0] wait_cnt;
  logic             in_acc;

  assign in_acc = (state == IACC) || (state == DACC);
  assign abort  = ~done & (wait_cnt == WaitW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= '0;
      memerr   <= 1'b0;
    end else begin
      wait_cnt <= in_acc ? wait_cnt + 1'b1 : '0;
      if (in_acc && abort) begin
        memerr <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      imemload <= '0;
      dmemload <= '0;
      wr_op    <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          dropped <= 1'b0;
          if (grant_i) begin
            ramaddr <= imemaddr;
            ramREN  <= 1'b1;
            wr_op   <= 1'b0;
            state   <= IACC;
          end else if (grant_d) begin
            // REN and WEN together is a write.
            ramaddr  <= dmemaddr;
            ramstore <= dmemstore;
            wr_op    <= dmemWEN;
            ramREN   <= ~dmemWEN;
            ramWEN   <= dmemWEN;
            state    <= DACC;
          end
        end
        IACC, DACC: begin
          if (done || abort) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (state == IACC) begin
              imemload <= load_val;
              ihit     <= req_live & ~dropped;
              state    <= IRESP;
            end else begin
              if (!wr_op || abort) begin
                dmemload <= load_val;
              end
              dhit  <= req_live & ~dropped;
              state <= DRESP;
            end
          end else if (!req_live) begin
            // Requester gave up: finish the RAM access but suppress the hit.
            dropped <= 1'b1;
          end
        end
        IRESP, DRESP: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_responder.sv
// Scoreboard bench for mem_request_responder: a transaction-level model predicts the grant order
// and load values; a bench RAM answers with random latency; a monitor checks every hit.
`timescale 1ns/1ps
module tb_mem_request_responder;
  import cpu_types_pkg::*;

  localparam int StarveMax = 4;

  logic      CLK = 1'b0;
  logic      nRST = 1'b0;
  logic      imemREN = 1'b0;
  word_t     imemaddr = '0;
  logic      dmemREN = 1'b0;
  logic      dmemWEN = 1'b0;
  word_t     dmemaddr = '0;
  word_t     dmemstore = '0;
  logic      ihit, dhit, ramREN, ramWEN;
  word_t     imemload, dmemload, ramaddr, ramstore;
  word_t     ramload;
  ramstate_t ramstate;
`ifdef MEM_RESP_TIMEOUT_EN
  logic      memerr;
`endif

  mem_request_responder #(
    .STARVE_MAX(StarveMax),
    .TIMEOUT   (64)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .dmemaddr (dmemaddr),
    .dmemstore(dmemstore),
    .ihit     (ihit),
    .dhit     (dhit),
    .imemload (imemload),
    .dmemload (dmemload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
`ifdef MEM_RESP_TIMEOUT_EN
    ,
    .memerr   (memerr)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit    is_i;
    bit    wr;
    word_t addr;
    word_t store;
    word_t load;
  } exp_t;

  exp_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    hit_cnt = 0;
  int    force_lat = -1;
  int    starve = 0;
  word_t ram[word_t];
  word_t mdl_mem[word_t];
  word_t mdl_dload = '0;

  word_t b_ia;
  word_t b_da[8];
  word_t b_ds[8];
  bit    b_dw[8];
  bit    b_both[8];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic word_t dflt(word_t a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic word_t ram_rd(word_t a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic word_t mdl_rd(word_t a);
    return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
  endfunction

  function automatic word_t rand_addr();
    return word_t'($urandom_range(0, 15)) << 2;
  endfunction

  function automatic void push_i(word_t a);
    exp_t e;
    e.is_i = 1'b1; e.wr = 1'b0; e.addr = a; e.store = '0; e.load = mdl_rd(a);
    exp_q.push_back(e);
  endfunction

  function automatic void push_d(word_t a, word_t s, bit w);
    exp_t e;
    e.is_i = 1'b0; e.wr = w; e.addr = a; e.store = s;
    if (w) begin
      mdl_mem[a] = s;
      e.load = mdl_dload;
    end else begin
      e.load = mdl_rd(a);
      mdl_dload = e.load;
    end
    exp_q.push_back(e);
  endfunction

  // Bench RAM: BUSY/FREE/ERROR for a chosen latency once strobed, then one ACCESS cycle.
  initial begin : ram_model
    int busy_left;
    bit armed;
    int ns;
    busy_left = 0;
    armed = 1'b0;
    ramstate = FREE;
    ramload = '0;
    forever begin
      @(negedge CLK);
      if (!(ramREN || ramWEN)) begin
        ramstate = FREE;
        armed = 1'b0;
      end else begin
        if (!armed) begin
          armed = 1'b1;
          busy_left = (force_lat < 0) ? int'($urandom_range(0, 3)) : force_lat;
          if (exp_q.size() > 0) begin
            check("ram_addr", ramaddr, exp_q[0].addr);
            check("ram_op", {30'b0, ramREN, ramWEN}, exp_q[0].wr ? 32'd1 : 32'd2);
            if (exp_q[0].wr) check("ram_store", ramstore, exp_q[0].store);
          end
        end
        if (busy_left > 0) begin
          ns = int'($urandom_range(0, 2));
          ramstate = (ns == 2) ? ERROR : (ns == 1 ? BUSY : FREE);
          ramload = $urandom;
          busy_left--;
        end else begin
          ramstate = ACCESS;
          if (ramWEN) begin
            ram[ramaddr] = ramstore;
            ramload = $urandom;
          end else begin
            ramload = ram_rd(ramaddr);
          end
        end
      end
    end
  end

  // Monitor: every hit pops the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST && (ihit || dhit)) begin
        hit_cnt++;
        check("single_hit", {31'b0, ihit & dhit}, 32'd0);
        check("strobes_in_hit", {30'b0, ramREN, ramWEN}, 32'd0);
        check("hit_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("hit_kind", {31'b0, ihit}, {31'b0, e.is_i});
          if (ihit) check("imemload", imemload, e.load);
          else      check("dmemload", dmemload, e.load);
        end
      end
    end
  end

  task automatic wait_hit(input bit want_i, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge CLK);
      seen = want_i ? ihit : dhit;
    end
    check(nm, {31'b0, seen}, 32'd1);
  endtask

  // One instruction request (optional) held while n data requests issue back-to-back.
  task automatic run_burst(input bit has_i, input int n);
    int di;
    bit ipend;
    di = 0;
    ipend = has_i;
    b_ia = rand_addr();
    for (int j = 0; j < n; j++) begin
      b_da[j] = rand_addr();
      b_ds[j] = $urandom;
      b_dw[j] = 1'($urandom_range(0, 1));
      b_both[j] = 1'($urandom_range(0, 1));
    end
    while (ipend || di < n) begin
      if (ipend && (di == n || starve == StarveMax)) begin
        push_i(b_ia);
        starve = 0;
        ipend = 1'b0;
      end else begin
        push_d(b_da[di], b_ds[di], b_dw[di]);
        if (ipend && starve < StarveMax) starve++;
        di++;
      end
    end
    fork
      begin
        if (has_i) begin
          imemaddr = b_ia;
          imemREN = 1'b1;
          wait_hit(1'b1, "ihit_arrives");
          imemREN = 1'b0;
        end
      end
      begin
        for (int j = 0; j < n; j++) begin
          dmemaddr = b_da[j];
          dmemstore = b_ds[j];
          dmemWEN = b_dw[j];
          dmemREN = b_dw[j] ? b_both[j] : 1'b1;
          wait_hit(1'b0, "dhit_arrives");
        end
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
      end
    join
  endtask

  initial begin : stim
    int n0;
    int hc;
    bit seen;
    exp_t e;

    repeat (2) @(negedge CLK);
    check("rst_ihit", {31'b0, ihit}, 32'd0);
    check("rst_dhit", {31'b0, dhit}, 32'd0);
    check("rst_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_imemload", imemload, 32'd0);
    check("rst_dmemload", dmemload, 32'd0);
`ifdef MEM_RESP_TIMEOUT_EN
    check("rst_memerr", {31'b0, memerr}, 32'd0);
`endif
    nRST = 1'b1;
    @(negedge CLK);

    // Instruction read with three non-ACCESS cycles: hit five cycles after the request.
    ram[32'h40] = 32'hDEADBEEF;
    mdl_mem[32'h40] = 32'hDEADBEEF;
    force_lat = 3;
    push_i(32'h40);
    imemaddr = 32'h40;
    imemREN = 1'b1;
    n0 = cyc;
    wait_hit(1'b1, "t1_ihit");
    check("t1_latency", cyc - n0, 32'd5);
    imemREN = 1'b0;
    @(negedge CLK);

    // Write: dmemload must stay as it was.
    force_lat = 2;
    push_d(32'h100, 32'h12345678, 1'b1);
    dmemaddr = 32'h100;
    dmemstore = 32'h12345678;
    dmemWEN = 1'b1;
    wait_hit(1'b0, "t4_dhit");
    dmemWEN = 1'b0;
    check("t4_ram_written", ram_rd(32'h100), 32'h12345678);
    force_lat = -1;

    // Conflict, then the starvation burst, then random traffic.
    run_burst(1'b1, 1);
    run_burst(1'b1, 5);
    for (int it = 0; it < 40; it++) begin
      bit hi;
      int nd;
      hi = 1'($urandom_range(0, 1));
      nd = int'($urandom_range(0, 6));
      if (!hi && nd == 0) nd = 1;
      run_burst(hi, nd);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    check("queue_drained", exp_q.size(), 32'd0);

    // Dropped data read: no hit, but the load register still updates.
    force_lat = 3;
    hc = hit_cnt;
    dmemaddr = 32'h20;
    dmemWEN = 1'b0;
    dmemREN = 1'b1;
    repeat (2) @(negedge CLK);
    dmemREN = 1'b0;
    repeat (8) @(negedge CLK);
    check("drop_no_hit", hit_cnt, hc);
    check("drop_load_updates", dmemload, mdl_rd(32'h20));
    mdl_dload = mdl_rd(32'h20);
    force_lat = -1;
    run_burst(1'b1, 1);

`ifdef MEM_RESP_TIMEOUT_EN
    force_lat = 1000;
    e.is_i = 1'b0; e.wr = 1'b0; e.addr = 32'h44; e.store = '0; e.load = BAD_LOAD;
    exp_q.push_back(e);
    mdl_dload = BAD_LOAD;
    dmemaddr = 32'h44;
    dmemREN = 1'b1;
    wait_hit(1'b0, "timeout_hit");
    dmemREN = 1'b0;
    check("memerr_set", {31'b0, memerr}, 32'd1);
    repeat (10) @(negedge CLK);
    check("memerr_sticky", {31'b0, memerr}, 32'd1);
    force_lat = -1;
`endif

    // Asynchronous reset in the middle of an instruction access.
    force_lat = 50;
    imemaddr = 32'h80;
    imemREN = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK);
      seen = ramREN;
    end
    check("iacc_entered", {31'b0, seen}, 32'd1);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("arst_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
    check("arst_hits", {30'b0, ihit, dhit}, 32'd0);
    check("arst_ramaddr", ramaddr, 32'd0);
    check("arst_ramstore", ramstore, 32'd0);
    check("arst_imemload", imemload, 32'd0);
    check("arst_dmemload", dmemload, 32'd0);
    imemREN = 1'b0;
    exp_q.delete();
    mdl_dload = '0;
    starve = 0;
    force_lat = -1;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    run_burst(1'b1, 2);
    check("final_queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
